// File: rtl/subckt_bist_ctrl_pkg.sv
// Shared types and constants for the subcircuit BIST sequencer.
package subckt_bist_pkg;

  localparam int unsigned MISR_W       = 16;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;  // x^16+x^14+x^13+x^11+1 -> bits 15,13,12,10
  localparam logic [15:0] MISR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_CMP,
    S_DONE
  } state_t;

  function automatic logic fb16(input logic [15:0] q, input logic [15:0] taps);
    return ^(q & taps);
  endfunction

endpackage

// File: rtl/subckt_bist_ctrl_if.sv
// Scheduler/subcircuit-facing signal bundle of the BIST sequencer.
interface subckt_bist_ctrl_if #(
  parameter int unsigned N_IN = 5
);
  import subckt_bist_pkg::*;

  logic              start;
  logic              abort;
  logic [MISR_W-1:0] golden_sig;
  logic              dut_out;
  logic [N_IN-1:0]   dut_in;
  logic              busy;
  logic              done;
  logic              pass;
  logic [MISR_W-1:0] signature;

  modport master (
    output start, abort, golden_sig, dut_out,
    input  dut_in, busy, done, pass, signature
  );

  modport slave (
    input  start, abort, golden_sig, dut_out,
    output dut_in, busy, done, pass, signature
  );

endinterface

// File: rtl/subckt_bist_ctrl_lfsr16.sv
// Seedable 16-bit Fibonacci shift register; din folds in a serial input (MISR use).
module bist_lfsr16
  import subckt_bist_pkg::*;
#(
  parameter logic [15:0] TAPS    = LFSR_TAPS,
  parameter logic [15:0] RST_VAL = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        en,
  input  logic        din,
  output logic [15:0] q,
  output logic [15:0] nxt_c
);

  always_comb begin
    nxt_c = q;
    if (load) begin
      nxt_c = seed;
    end else if (en) begin
      nxt_c = {q[14:0], fb16(q, TAPS) ^ din};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST_VAL;
    else        q <= nxt_c;
  end

endmodule

// File: rtl/subckt_bist_ctrl.sv
// BIST sequencer: LFSR stimulus into the subcircuit, MISR compaction of its output,
// golden-signature compare reported through a start/done handshake.
module subckt_bist_ctrl
  import subckt_bist_pkg::*;
#(
  parameter int unsigned N_IN      = 5,
  parameter int unsigned N_PAT     = 256,
  parameter int unsigned LAT       = 2,
  parameter logic [15:0] LFSR_SEED = DEFAULT_SEED
) (
  input logic               I1470,
  input logic               I1477,
  subckt_bist_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = (N_PAT > 1) ? $clog2(N_PAT) : 1;
  localparam int unsigned DRN_W = (LAT > 1) ? $clog2(LAT) : 1;

  state_t            state, state_d;
  logic [CNT_W-1:0]  pat_cnt, pat_cnt_d;
  logic [DRN_W-1:0]  drn_cnt, drn_cnt_d;
  logic [LAT-1:0]    vpipe, vpipe_d;
  logic              tok;
  logic              lfsr_load, lfsr_en, misr_load;
  logic [15:0]       lfsr_q, lfsr_nxt, misr_q, misr_nxt;
  logic [N_IN-1:0]   dut_in_q, dut_in_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [MISR_W-1:0] sig_q, sig_d;
  logic              unused_c;

  bist_lfsr16 #(.TAPS(LFSR_TAPS), .RST_VAL(LFSR_SEED)) u_lfsr (
    .clk(I1470), .rst_n(I1477), .load(lfsr_load), .seed(LFSR_SEED),
    .en(lfsr_en), .din(1'b0), .q(lfsr_q), .nxt_c(lfsr_nxt)
  );

  // MISR: advances only when a pattern's response reaches the end of the latency pipe
  bist_lfsr16 #(.TAPS(MISR_TAPS), .RST_VAL(16'h0000)) u_misr (
    .clk(I1470), .rst_n(I1477), .load(misr_load), .seed(16'h0000),
    .en(vpipe[LAT-1]), .din(bus.dut_out), .q(misr_q), .nxt_c(misr_nxt)
  );

  assign unused_c = ^{lfsr_q, lfsr_nxt, misr_nxt};

  always_comb begin
    state_d   = state;
    pat_cnt_d = pat_cnt;
    drn_cnt_d = drn_cnt;
    tok       = 1'b0;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    misr_load = 1'b0;
    pass_d    = pass_q;
    sig_d     = sig_q;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_RUN;
          lfsr_load = 1'b1;
          misr_load = 1'b1;
          pat_cnt_d = '0;
          drn_cnt_d = '0;
          pass_d    = 1'b0;
          sig_d     = '0;
        end
      end
      S_RUN: begin
        lfsr_en   = 1'b1;
        tok       = 1'b1;
        pat_cnt_d = pat_cnt + CNT_W'(1);
        if (pat_cnt == CNT_W'(N_PAT - 1)) begin
          state_d   = S_DRAIN;
          drn_cnt_d = '0;
        end
      end
      S_DRAIN: begin
        drn_cnt_d = drn_cnt + DRN_W'(1);
        if (drn_cnt == DRN_W'(LAT - 1)) state_d = S_CMP;
      end
      S_CMP: begin
        state_d = S_DONE;
        sig_d   = misr_q;
        pass_d  = (misr_q == bus.golden_sig);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    vpipe_d[0] = tok;
    for (int i = 1; i < int'(LAT); i++) vpipe_d[i] = vpipe[i-1];

    if (bus.abort && (state == S_RUN || state == S_DRAIN || state == S_CMP)) begin
      state_d = S_IDLE;
      vpipe_d = '0;
      pass_d  = 1'b0;
      sig_d   = sig_q;
    end

    // Outputs are registered from the next state so they line up with it
    busy_d   = (state_d == S_RUN) || (state_d == S_DRAIN) || (state_d == S_CMP);
    done_d   = (state_d == S_DONE);
    dut_in_d = (state_d == S_RUN) ? lfsr_nxt[N_IN-1:0] : '0;
  end

  always_ff @(posedge I1470 or negedge I1477) begin
    if (!I1477) begin
      state    <= S_IDLE;
      pat_cnt  <= '0;
      drn_cnt  <= '0;
      vpipe    <= '0;
      dut_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      sig_q    <= '0;
    end else begin
      state    <= state_d;
      pat_cnt  <= pat_cnt_d;
      drn_cnt  <= drn_cnt_d;
      vpipe    <= vpipe_d;
      dut_in_q <= dut_in_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      sig_q    <= sig_d;
    end
  end

  assign bus.dut_in    = dut_in_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.signature = sig_q;

endmodule

// File: tb/tb_subckt_bist_ctrl.sv
// Bench for subckt_bist_ctrl: directed runs with a done-triggered scoreboard.
module tb_subckt_bist_ctrl;
  import subckt_bist_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  subckt_bist_ctrl_if #(.N_IN(5)) bd ();
  subckt_bist_ctrl_if #(.N_IN(5)) b4 ();

  subckt_bist_ctrl #(.N_IN(5)) u_def (.I1470(clk), .I1477(rst_n), .bus(bd));
  subckt_bist_ctrl #(.N_IN(5), .N_PAT(4), .LAT(2)) u_p4 (.I1470(clk), .I1477(rst_n), .bus(b4));

  typedef struct packed {
    logic [15:0] sig;
    logic        pass;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int errors = 0;
  int checks = 0;
  int bc, da, dc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] sig, input logic pass);
    exp_t x;
    x.sig  = sig;
    x.pass = pass;
    exp_q.push_back(x);
  endtask

  // Monitor: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (rst_n && b4.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending run");
      end else begin
        e = exp_q.pop_front();
        chk("signature", 32'(b4.signature), 32'(e.sig));
        chk("pass", 32'(b4.pass), 32'(e.pass));
      end
    end
  end

  // Called at a negedge in IDLE; dpat[k] is dut_out driven during cycle k after the start edge
  task automatic do_run(input logic [15:0] gold, input logic [15:0] dpat, input int restart_k,
                        output int busy_cnt, output int done_at, output int done_cnt);
    busy_cnt = 0;
    done_at  = 0;
    done_cnt = 0;
    b4.golden_sig = gold;
    b4.dut_out    = dpat[0];
    b4.start      = 1'b1;
    @(negedge clk);
    b4.start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (b4.busy) busy_cnt++;
      if (b4.done) begin
        done_cnt++;
        done_at = k;
      end
      b4.start   = (k == restart_k);
      b4.dut_out = dpat[4'(k)];
      @(negedge clk);
    end
    b4.start   = 1'b0;
    b4.dut_out = 1'b0;
  endtask

  initial begin
    bd.start = 1'b0; bd.abort = 1'b0; bd.golden_sig = '0; bd.dut_out = 1'b0;
    b4.start = 1'b0; b4.abort = 1'b0; b4.golden_sig = '0; b4.dut_out = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(b4.busy), 32'd0);
    chk("rst_done", 32'(b4.done), 32'd0);
    chk("rst_pass", 32'(b4.pass), 32'd0);
    chk("rst_signature", 32'(b4.signature), 32'd0);
    chk("rst_dut_in", 32'(b4.dut_in), 32'd0);
    chk("rst_def_dut_in", 32'(bd.dut_in), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Default instance: first two LFSR patterns, then abort out of RUN
    bd.start = 1'b1;
    @(negedge clk);
    bd.start = 1'b0;
    chk("def_dut_in_1", 32'(bd.dut_in), 32'h01);
    chk("def_busy", 32'(bd.busy), 32'd1);
    @(negedge clk);
    chk("def_dut_in_2", 32'(bd.dut_in), 32'h03);
    bd.abort = 1'b1;
    @(negedge clk);
    bd.abort = 1'b0;
    chk("def_abort_busy", 32'(bd.busy), 32'd0);
    chk("def_abort_dut_in", 32'(bd.dut_in), 32'd0);

    // dut_out tied 1: 0 -> 1 -> 3 -> 7 -> F
    push_exp(16'h000F, 1'b1);
    do_run(16'h000F, 16'hFFFF, 0, bc, da, dc);
    chk("a_busy_cycles", 32'(bc), 32'd7);
    chk("a_done_at", 32'(da), 32'd8);
    chk("a_done_count", 32'(dc), 32'd1);
    chk("a_held_pass", 32'(b4.pass), 32'd1);
    chk("a_held_signature", 32'(b4.signature), 32'h000F);

    // dut_out tied 0 against a nonzero golden value
    push_exp(16'h0000, 1'b0);
    do_run(16'h0001, 16'h0000, 0, bc, da, dc);
    chk("b_busy_cycles", 32'(bc), 32'd7);
    chk("b_done_count", 32'(dc), 32'd1);

    // Second start during RUN is ignored
    push_exp(16'h000F, 1'b1);
    do_run(16'h000F, 16'hFFFF, 2, bc, da, dc);
    chk("c_done_count", 32'(dc), 32'd1);
    chk("c_done_at", 32'(da), 32'd8);

    // Sampling window: cycles 3..6 carry 1,0,1,1 -> 0x000B; neighbours are 1
    push_exp(16'h000B, 1'b1);
    do_run(16'h000B, 16'h00EE, 0, bc, da, dc);
    chk("d_done_at", 32'(da), 32'd8);

    // Abort on the third RUN cycle
    b4.golden_sig = 16'h000F;
    b4.dut_out    = 1'b1;
    b4.start      = 1'b1;
    @(negedge clk);
    b4.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("e_busy_before_abort", 32'(b4.busy), 32'd1);
    b4.abort = 1'b1;
    @(negedge clk);
    b4.abort = 1'b0;
    chk("e_abort_busy", 32'(b4.busy), 32'd0);
    chk("e_abort_dut_in", 32'(b4.dut_in), 32'd0);
    chk("e_abort_pass", 32'(b4.pass), 32'd0);
    chk("e_abort_signature", 32'(b4.signature), 32'd0);
    dc = 0;
    for (int k = 0; k < 10; k++) begin
      if (b4.done) dc++;
      @(negedge clk);
    end
    chk("e_abort_no_done", 32'(dc), 32'd0);
    push_exp(16'h000F, 1'b1);
    do_run(16'h000F, 16'hFFFF, 0, bc, da, dc);
    chk("e_rerun_done_count", 32'(dc), 32'd1);

    // Asynchronous reset in the first DRAIN cycle
    b4.golden_sig = 16'h000F;
    b4.dut_out    = 1'b1;
    b4.start      = 1'b1;
    @(negedge clk);
    b4.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("f_busy_in_drain", 32'(b4.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("f_rst_busy", 32'(b4.busy), 32'd0);
    chk("f_rst_dut_in", 32'(b4.dut_in), 32'd0);
    chk("f_rst_done", 32'(b4.done), 32'd0);
    chk("f_rst_signature", 32'(b4.signature), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dc = 0;
    for (int k = 0; k < 12; k++) begin
      if (b4.done) dc++;
      @(negedge clk);
    end
    chk("f_no_done_after_reset", 32'(dc), 32'd0);
    b4.dut_out = 1'b0;

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
